bcd_to_binary_seq: RTL

//  Sequential packed-BCD to unsigned binary converter, the inverse of the binary->octal/hex/decimal block.

---
 rtl/bcd_to_binary_seq_if.sv | 24 ++
 rtl/bcd_to_binary_seq.sv | 129 ++++++++++++
 2 files changed

// File: rtl/bcd_to_binary_seq_if.sv
// Handshake bundle for the sequential BCD-to-binary converter.
// The master side issues BCD words and takes results. The slave side is the converter.
interface bcd_to_binary_seq_if #(
   parameter int DIGITS = 3,
   parameter int BIN_W  = 10
);
   logic [4*DIGITS-1:0] bcd;
   logic                in_valid;
   logic                in_ready;
   logic [BIN_W-1:0]    binary;
   logic                err;
   logic                out_valid;
   logic                out_ready;

   modport master (
      output bcd, in_valid, out_ready,
      input  in_ready, binary, err, out_valid
   );

   modport slave (
      input  bcd, in_valid, out_ready,
      output in_ready, binary, err, out_valid
   );
endinterface

// File: rtl/bcd_to_binary_seq.sv
// Sequential packed-BCD to unsigned binary converter (reverse double-dabble).
// Each SHIFT cycle performs one right shift through {s_bcd, s_bin}.
// Every shifted digit that is >= 8 then has 3 subtracted from it.
// After BIN_W such cycles, s_bin holds the binary value.
//
// state | meaning
// IDLE  | waiting for a word; in_ready high
// SHIFT | BIN_W iterations of shift + digit correction
// HOLD  | result/err presented with out_valid until out_ready
module bcd_to_binary_seq #(
   parameter int DIGITS = 3,
   parameter int BIN_W  = 10
) (
   input  logic                clk,
   input  logic                rst,
   bcd_to_binary_seq_if.slave  bus
);
   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

   function automatic longint unsigned pow10(input int n);
      longint unsigned p;
      p = 64'd1;
      for (int i = 0; i < n; i++) p = p * 64'd10;
      return p;
   endfunction

   // The result register must hold 10**DIGITS - 1 without truncation.
   generate
      if (DIGITS < 1 || BIN_W < 2 ||
          (BIN_W < 64 && ((64'd1 << BIN_W) < pow10(DIGITS)))) begin : g_width_check
         $error("bcd_to_binary_seq: BIN_W too small for DIGITS");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [BCD_W-1:0]   s_bcd;
   logic [BCD_W-1:0]   s_bcd_shift;
   logic [BCD_W-1:0]   s_bcd_fix;
   logic [BIN_W-1:0]   s_bin;
   logic [BIN_W-1:0]   s_bin_shift;
   logic [CNT_W-1:0]   cnt;
   logic [BIN_W-1:0]   binary_q;
   logic               err_q;
   logic               digit_bad;
   logic               last_iter;

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == HOLD);
   assign bus.binary    = binary_q;
   assign bus.err       = err_q;

   assign last_iter = (cnt == CNT_W'(BIN_W - 1));

   // Flag any incoming digit outside 0..9.
   always_comb begin
      digit_bad = 1'b0;
      for (int d = 0; d < DIGITS; d++) begin
         if (bus.bcd[4*d +: 4] > 4'd9) digit_bad = 1'b1;
      end
   end

   // One reverse double-dabble step: shift right, then correct each digit >= 8.
   // A corrected digit is at least 8, so subtracting 3 can never underflow.
   always_comb begin
      s_bcd_shift = {1'b0, s_bcd[BCD_W-1:1]};
      s_bin_shift = {s_bcd[0], s_bin[BIN_W-1:1]};
      s_bcd_fix   = s_bcd_shift;
      for (int d = 0; d < DIGITS; d++) begin
         if (s_bcd_shift[4*d +: 4] >= 4'd8) s_bcd_fix[4*d +: 4] = s_bcd_shift[4*d +: 4] - 4'd3;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.in_valid) state_nxt = digit_bad ? HOLD : SHIFT;
         SHIFT:   if (last_iter)    state_nxt = HOLD;
         HOLD:    if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: load on accept, iterate in SHIFT, capture result on the last step.
   // binary_q holds its value until the next completion, even after HOLD is left.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_bcd    <= '0;
         s_bin    <= '0;
         cnt      <= '0;
         binary_q <= '0;
         err_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  s_bcd <= bus.bcd;
                  s_bin <= '0;
                  cnt   <= '0;
                  err_q <= digit_bad;
                  if (digit_bad) binary_q <= '0;
               end
            end
            SHIFT: begin
               s_bcd <= s_bcd_fix;
               s_bin <= s_bin_shift;
               cnt   <= cnt + CNT_W'(1);
               if (last_iter) binary_q <= s_bin_shift;
            end
            default: begin
            end
         endcase
      end
   end
endmodule
